// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the note-program fetch sequencer: opcode constants,
// reset/default values, the sequencer state enumeration and a helper that
// splits a rep2 instruction into its fields.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    // Upper nibble opcodes for non-note instructions (ins[15] = 0).
    localparam logic [3:0] OP_END  = 4'b0000;
    localparam logic [3:0] OP_BPM  = 4'b0001;
    localparam logic [3:0] OP_REP1 = 4'b0010;
    localparam logic [3:0] OP_REP2 = 4'b0011;

    localparam logic [11:0] BPM_DEFAULT      = 12'd96;
    localparam logic [15:0] NOTE_PLACEHOLDER = 16'h8001;

    localparam int REP_LEVELS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_HALT   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    typedef struct packed {
        logic [5:0] lo;
        logic [2:0] count;
        logic [2:0] level;
    } rep2_fields_t;

    function automatic rep2_fields_t decode_rep2(input logic [15:0] ins);
        rep2_fields_t f;
        f.lo    = ins[11:6];
        f.count = ins[5:3];
        f.level = ins[2:0];
        return f;
    endfunction

endpackage

// File: rtl/fetch_sequencer_rep_counter_bank.sv
// -----------------------------------------------------------------------------
// rep_counter_bank
// Eight 3-bit loop counters with a single read/update port selected by level.
// On an update strobe the addressed counter is evaluated and the bank reports
// whether the sequencer should branch back to the loop target:
//   counter=0, count=0 : fall through, counter unchanged
//   counter=0, count>0 : load count, branch
//   counter=1          : clear, fall through
//   counter>1          : decrement, branch
// A loop with count N therefore runs its body N+1 times, and because the
// counter returns to 0 on exit an inner loop re-arms on every outer pass.
//
// Ports
//   clk_i     in   clock
//   rst_ni    in   synchronous active-low reset, clears all counters
//   clr_i     in   clear all counters (program restart)
//   upd_i     in   evaluate/update the counter selected by level_i
//   level_i   in   counter index
//   count_i   in   repeat count carried by the rep2 instruction
//   branch_o  out  1 = take the loop branch this update
// -----------------------------------------------------------------------------
module rep_counter_bank
    import fetch_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       upd_i,
    input  logic [2:0] level_i,
    input  logic [2:0] count_i,
    output logic       branch_o
);

    logic [REP_LEVELS-1:0][2:0] cnt_q;
    logic [REP_LEVELS-1:0][2:0] cnt_d;
    logic [2:0]                 cur;

    assign cur = cnt_q[level_i];

    always_comb begin
        cnt_d    = cnt_q;
        branch_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (upd_i) begin
            if (cur == 3'd0) begin
                if (count_i != 3'd0) begin
                    cnt_d[level_i] = count_i;
                    branch_o       = 1'b1;
                end
            end else if (cur == 3'd1) begin
                cnt_d[level_i] = 3'd0;
            end else begin
                cnt_d[level_i] = cur - 3'd1;
                branch_o       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetches 16-bit instructions from a synchronous-latency SRAM, executes tempo
// and loop control instructions internally and offers note instructions to an
// external executor through a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | after reset, waiting for START
// FETCH   | SRAM_A = pc held READ_LATENCY cycles, SRAM_D latched on last edge
// DECODE  | execute the latched instruction, choose next pc / state
// EMIT    | NOTE_VALID high until NOTE_READY
// HALT    | END instruction reached, DONE high, waiting for START
// ERR     | reserved opcode decoded, ERROR high, waiting for START
//
// Ports
//   CLK         in   clock, all state changes on rising edge
//   RESET_N     in   synchronous active-low reset
//   START       in   start playback at PC_BASE (IDLE/HALT/ERR only)
//   SRAM_A      out  instruction address (always the current pc)
//   SRAM_D      in   instruction word
//   NOTE_VALID  out  note offered to the executor
//   NOTE_INS    out  note word
//   NOTE_BPM    out  tempo in force for NOTE_INS
//   NOTE_READY  in   executor accepts the note
//   DONE        out  high in HALT
//   ERROR       out  high in ERR
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [17:0] PC_BASE      = 18'h0FF00,
    parameter int          READ_LATENCY = 2,
    parameter logic [11:0] DEFAULT_BPM  = BPM_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    output logic [17:0] SRAM_A,
    input  logic [15:0] SRAM_D,
    output logic        NOTE_VALID,
    output logic [15:0] NOTE_INS,
    output logic [11:0] NOTE_BPM,
    input  logic        NOTE_READY,
    output logic        DONE,
    output logic        ERROR
);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("fetch_sequencer: READ_LATENCY must be within 1..7");
    end

    // The latency timer counts down to zero; SRAM_D is captured when it
    // reaches zero, so FETCH lasts exactly READ_LATENCY cycles.
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    state_t       state_q,    state_d;
    logic [17:0]  pc_q,       pc_d;
    logic [11:0]  bpm_q,      bpm_d;
    logic [11:0]  rep_hi_q,   rep_hi_d;
    logic [2:0]   lat_q,      lat_d;
    logic [15:0]  ins_q,      ins_d;
    logic [15:0]  note_ins_q, note_ins_d;
    logic [11:0]  note_bpm_q, note_bpm_d;

    logic         rep_clr;
    logic         rep_upd;
    logic         rep_branch;
    rep2_fields_t rep2;

    assign rep2 = decode_rep2(ins_q);

    rep_counter_bank u_rep (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .clr_i    (rep_clr),
        .upd_i    (rep_upd),
        .level_i  (rep2.level),
        .count_i  (rep2.count),
        .branch_o (rep_branch)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bpm_d      = bpm_q;
        rep_hi_d   = rep_hi_q;
        lat_d      = lat_q;
        ins_d      = ins_q;
        note_ins_d = note_ins_q;
        note_bpm_d = note_bpm_q;
        rep_clr    = 1'b0;
        rep_upd    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT, ST_ERR: begin
                if (START) begin
                    state_d  = ST_FETCH;
                    pc_d     = PC_BASE;
                    bpm_d    = DEFAULT_BPM;
                    rep_hi_d = 12'd0;
                    rep_clr  = 1'b1;
                    lat_d    = LAT_INIT;
                end
            end

            ST_FETCH: begin
                if (lat_q == 3'd0) begin
                    ins_d   = SRAM_D;
                    state_d = ST_DECODE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end

            ST_DECODE: begin
                // Every exit towards FETCH needs a fresh latency count.
                lat_d = LAT_INIT;
                if (ins_q[15]) begin
                    note_ins_d = ins_q;
                    note_bpm_d = bpm_q;
                    pc_d       = pc_q + 18'd1;
                    state_d    = ST_EMIT;
                end else begin
                    unique case (ins_q[15:12])
                        OP_END: begin
                            state_d = ST_HALT;
                        end
                        OP_BPM: begin
                            bpm_d   = ins_q[11:0];
                            pc_d    = pc_q + 18'd1;
                            state_d = ST_FETCH;
                        end
                        OP_REP1: begin
                            rep_hi_d = ins_q[11:0];
                            pc_d     = pc_q + 18'd1;
                            state_d  = ST_FETCH;
                        end
                        OP_REP2: begin
                            rep_upd = 1'b1;
                            pc_d    = rep_branch ? {rep_hi_q, rep2.lo} : (pc_q + 18'd1);
                            state_d = ST_FETCH;
                        end
                        default: begin
                            state_d = ST_ERR;
                        end
                    endcase
                end
            end

            ST_EMIT: begin
                if (NOTE_READY) begin
                    state_d = ST_FETCH;
                    lat_d   = LAT_INIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_BASE;
            bpm_q      <= DEFAULT_BPM;
            rep_hi_q   <= 12'd0;
            lat_q      <= LAT_INIT;
            ins_q      <= NOTE_PLACEHOLDER;
            note_ins_q <= NOTE_PLACEHOLDER;
            note_bpm_q <= DEFAULT_BPM;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bpm_q      <= bpm_d;
            rep_hi_q   <= rep_hi_d;
            lat_q      <= lat_d;
            ins_q      <= ins_d;
            note_ins_q <= note_ins_d;
            note_bpm_q <= note_bpm_d;
        end
    end

    assign SRAM_A     = pc_q;
    assign NOTE_VALID = (state_q == ST_EMIT);
    assign NOTE_INS   = note_ins_q;
    assign NOTE_BPM   = note_bpm_q;
    assign DONE       = (state_q == ST_HALT);
    assign ERROR      = (state_q == ST_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Two sequencer instances: dut_a with default parameters (PC_BASE=0FF00,
// READ_LATENCY=2) and dut_w with PC_BASE=3FFFF, READ_LATENCY=1 for the
// address wrap and error/restart scenarios. Each has a small SRAM model that
// returns a reserved opcode until the address has been held READ_LATENCY
// cycles, so an early capture shows up as ERROR.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- dut_a ----------------
    logic        rst_n_a, start_a, ready_a;
    logic [17:0] a_a;
    logic [15:0] d_a;
    logic        v_a, done_a, err_a;
    logic [15:0] ins_a;
    logic [11:0] bpm_a;
    logic [15:0] mem_a [64];
    int          held_a = 0;
    logic [17:0] last_a = '1;

    fetch_sequencer dut_a (
        .CLK(CLK), .RESET_N(rst_n_a), .START(start_a),
        .SRAM_A(a_a), .SRAM_D(d_a),
        .NOTE_VALID(v_a), .NOTE_INS(ins_a), .NOTE_BPM(bpm_a), .NOTE_READY(ready_a),
        .DONE(done_a), .ERROR(err_a)
    );

    // ---------------- dut_w ----------------
    logic        rst_n_w, start_w, ready_w;
    logic [17:0] a_w;
    logic [15:0] d_w;
    logic        v_w, done_w, err_w;
    logic [15:0] ins_w;
    logic [11:0] bpm_w;
    logic [15:0] mem_w [64];
    int          held_w = 0;
    logic [17:0] last_w = '1;

    fetch_sequencer #(.PC_BASE(18'h3FFFF), .READ_LATENCY(1)) dut_w (
        .CLK(CLK), .RESET_N(rst_n_w), .START(start_w),
        .SRAM_A(a_w), .SRAM_D(d_w),
        .NOTE_VALID(v_w), .NOTE_INS(ins_w), .NOTE_BPM(bpm_w), .NOTE_READY(ready_w),
        .DONE(done_w), .ERROR(err_w)
    );

    // SRAM models: data valid once the address has been presented for
    // READ_LATENCY cycles (counted at falling edges).
    always @(negedge CLK) begin
        if (a_a == last_a) held_a = held_a + 1; else held_a = 1;
        last_a = a_a;
        if (a_w == last_w) held_w = held_w + 1; else held_w = 1;
        last_w = a_w;
    end
    assign d_a = (held_a >= 2) ? mem_a[a_a[5:0]] : 16'h4444;
    assign d_w = (held_w >= 1) ? mem_w[a_w[5:0]] : 16'h4444;

    // Note collectors: inputs only change 1 time unit after a rising edge,
    // so at the falling edge valid&&ready means a handshake at the next edge.
    logic [15:0] qi_a[$];
    logic [11:0] qb_a[$];
    logic [15:0] qi_w[$];
    logic [11:0] qb_w[$];
    always @(negedge CLK) begin
        if (v_a && ready_a) begin qi_a.push_back(ins_a); qb_a.push_back(bpm_a); end
        if (v_w && ready_w) begin qi_w.push_back(ins_w); qb_w.push_back(bpm_w); end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem_a();
        for (int i = 0; i < 64; i++) mem_a[i] = 16'h0000;
    endtask

    task automatic reset_a();
        rst_n_a = 1'b0; start_a = 1'b0; ready_a = 1'b0;
        step(); step();
        rst_n_a = 1'b1;
        qi_a.delete(); qb_a.delete();
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_end_a(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!(done_a || err_a) && cycles < budget) begin
            step();
            cycles++;
        end
        check({name, "_ended"}, 32'(done_a | err_a), 32'd1);
    endtask

    task automatic wait_end_w(input string name, input int budget);
        int cycles = 0;
        while (!(done_w || err_w) && cycles < budget) begin
            step();
            cycles++;
        end
        check({name, "_ended"}, 32'(done_w | err_w), 32'd1);
    endtask

    function automatic logic [15:0] qi_a_at(input int i);
        return (qi_a.size() > i) ? qi_a[i] : 16'hFFFF;
    endfunction

    typedef struct {
        string       name;
        logic [15:0] ins;
        logic [17:0] exp_a;
        logic        exp_v;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_ins;
        logic [11:0] exp_bpm;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int cyc;
        int bad;
        logic [15:0] exp9 [9];
        logic [15:0] snap_ins;
        logic [11:0] snap_bpm;
        logic [17:0] snap_a;

        // Single-instruction decode table: state observed right after the
        // DECODE edge (START edge + READ_LATENCY + 1 edges).
        vecs[0] = '{"note",       16'h8123, 18'h0FF01, 1'b1, 1'b0, 1'b0, 16'h8123, 12'd96};
        vecs[1] = '{"end",        16'h0000, 18'h0FF00, 1'b0, 1'b1, 1'b0, 16'h8001, 12'd96};
        vecs[2] = '{"bpm",        16'h1078, 18'h0FF01, 1'b0, 1'b0, 1'b0, 16'h8001, 12'd96};
        vecs[3] = '{"rep1",       16'h2005, 18'h0FF01, 1'b0, 1'b0, 1'b0, 16'h8001, 12'd96};
        vecs[4] = '{"rep2_cnt0",  16'h30C0, 18'h0FF01, 1'b0, 1'b0, 1'b0, 16'h8001, 12'd96};
        vecs[5] = '{"rep2_cnt3",  16'h315A, 18'h00005, 1'b0, 1'b0, 1'b0, 16'h8001, 12'd96};
        vecs[6] = '{"op4",        16'h4000, 18'h0FF00, 1'b0, 1'b0, 1'b1, 16'h8001, 12'd96};
        vecs[7] = '{"op5",        16'h5ABC, 18'h0FF00, 1'b0, 1'b0, 1'b1, 16'h8001, 12'd96};
        vecs[8] = '{"op7",        16'h7FFF, 18'h0FF00, 1'b0, 1'b0, 1'b1, 16'h8001, 12'd96};

        rst_n_a = 1'b0; start_a = 1'b0; ready_a = 1'b0;
        rst_n_w = 1'b0; start_w = 1'b0; ready_w = 1'b0;
        clear_mem_a();
        for (int i = 0; i < 64; i++) mem_w[i] = 16'h0000;
        step(); step();

        // ---- reset state ----
        reset_a();
        check("rst_sram_a",     32'(a_a),    32'h0FF00);
        check("rst_note_valid", 32'(v_a),    32'd0);
        check("rst_done",       32'(done_a), 32'd0);
        check("rst_error",      32'(err_a),  32'd0);
        check("rst_note_ins",   32'(ins_a),  32'h8001);
        check("rst_note_bpm",   32'(bpm_a),  32'd96);

        // ---- decode table ----
        for (int k = 0; k < 9; k++) begin
            clear_mem_a();
            mem_a[0] = vecs[k].ins;
            mem_a[1] = 16'h8ABC;
            reset_a();
            start_pulse_a();
            repeat (3) step();
            check({vecs[k].name, "_sram_a"}, 32'(a_a),    32'(vecs[k].exp_a));
            check({vecs[k].name, "_valid"},  32'(v_a),    32'(vecs[k].exp_v));
            check({vecs[k].name, "_done"},   32'(done_a), 32'(vecs[k].exp_done));
            check({vecs[k].name, "_error"},  32'(err_a),  32'(vecs[k].exp_err));
            check({vecs[k].name, "_ins"},    32'(ins_a),  32'(vecs[k].exp_ins));
            check({vecs[k].name, "_bpm"},    32'(bpm_a),  32'(vecs[k].exp_bpm));
        end

        // ---- BPM 120, note A, END ----
        clear_mem_a();
        mem_a[0] = 16'h1078; mem_a[1] = 16'h8A00; mem_a[2] = 16'h0000;
        reset_a();
        ready_a = 1'b1;
        start_pulse_a();
        wait_end_a("prog_bpm", 40, cyc);
        check("prog_bpm_done_edge", 32'(cyc), 32'd10);
        check("prog_bpm_done",      32'(done_a), 32'd1);
        check("prog_bpm_notes",     32'(qi_a.size()), 32'd1);
        check("prog_bpm_ins",       32'(qi_a_at(0)), 32'h8A00);
        check("prog_bpm_bpm",       32'((qb_a.size() > 0) ? qb_a[0] : 12'hFFF), 32'd120);

        // ---- single loop: 3 notes repeated 3 times ----
        clear_mem_a();
        mem_a[0] = 16'h8100; mem_a[1] = 16'h8200; mem_a[2] = 16'h8300;
        mem_a[3] = 16'h23FC; mem_a[4] = 16'h3010; mem_a[5] = 16'h0000;
        reset_a();
        ready_a = 1'b1;
        start_pulse_a();
        wait_end_a("loop1", 500, cyc);
        check("loop1_done",  32'(done_a), 32'd1);
        check("loop1_notes", 32'(qi_a.size()), 32'd9);
        for (int i = 0; i < 9; i++) exp9[i] = 16'h8100 + 16'((i % 3 + 1) * 16'h0100) - 16'h0100;
        for (int i = 0; i < 9; i++) check($sformatf("loop1_note%0d", i), 32'(qi_a_at(i)), 32'(exp9[i]));
        check("loop1_cnt0", 32'(dut_a.u_rep.cnt_q[0]), 32'd0);

        // ---- nested loops: outer L1 count 1 around inner L0 count 2 ----
        clear_mem_a();
        mem_a[0] = 16'h23FC; mem_a[1] = 16'h8400; mem_a[2] = 16'h3050;
        mem_a[3] = 16'h3049; mem_a[4] = 16'h0000;
        reset_a();
        ready_a = 1'b1;
        start_pulse_a();
        wait_end_a("nest", 500, cyc);
        check("nest_done",  32'(done_a), 32'd1);
        check("nest_notes", 32'(qi_a.size()), 32'd6);
        check("nest_cnt0",  32'(dut_a.u_rep.cnt_q[0]), 32'd0);
        check("nest_cnt1",  32'(dut_a.u_rep.cnt_q[1]), 32'd0);

        // ---- back-pressure: NOTE_READY low 50 cycles, START ignored ----
        clear_mem_a();
        mem_a[0] = 16'h1123; mem_a[1] = 16'h8555; mem_a[2] = 16'h0000;
        reset_a();
        start_pulse_a();
        cyc = 0;
        while (!v_a && cyc < 20) begin step(); cyc++; end
        check("hold_valid_seen", 32'(v_a), 32'd1);
        snap_ins = ins_a; snap_bpm = bpm_a; snap_a = a_a;
        check("hold_ins",    32'(snap_ins), 32'h8555);
        check("hold_bpm",    32'(snap_bpm), 32'h123);
        check("hold_sram_a", 32'(snap_a),   32'h0FF02);
        bad = 0;
        start_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!v_a || ins_a !== snap_ins || bpm_a !== snap_bpm || a_a !== snap_a) bad++;
        end
        start_a = 1'b0;
        check("hold_unstable_cycles", 32'(bad), 32'd0);
        ready_a = 1'b1;
        wait_end_a("hold", 40, cyc);
        check("hold_done",  32'(done_a), 32'd1);
        check("hold_notes", 32'(qi_a.size()), 32'd1);

        // ---- dut_w: wrap, reset during EMIT, error at pc 3, restart ----
        mem_w[63] = 16'h8111; mem_w[0] = 16'h8222; mem_w[1] = 16'h1050;
        mem_w[2]  = 16'h8333; mem_w[3] = 16'h5000;
        rst_n_w = 1'b1;
        start_w = 1'b1; step(); start_w = 0;
        cyc = 0;
        while (!v_w && cyc < 20) begin step(); cyc++; end
        check("wrap_valid", 32'(v_w),   32'd1);
        check("wrap_ins",   32'(ins_w), 32'h8111);
        check("wrap_pc",    32'(a_w),   32'h00000);
        rst_n_w = 1'b0;
        step();
        check("emit_rst_valid",  32'(v_w),   32'd0);
        check("emit_rst_ins",    32'(ins_w), 32'h8001);
        check("emit_rst_sram_a", 32'(a_w),   32'h3FFFF);
        rst_n_w = 1'b1;
        qi_w.delete(); qb_w.delete();
        ready_w = 1'b1;
        start_w = 1'b1; step(); start_w = 1'b0;
        wait_end_w("err", 60);
        check("err_error",  32'(err_w),  32'd1);
        check("err_done",   32'(done_w), 32'd0);
        check("err_pc",     32'(a_w),    32'h00003);
        check("err_notes",  32'(qi_w.size()), 32'd3);
        check("err_note1",  32'((qi_w.size() > 1) ? qi_w[1] : 16'hFFFF), 32'h8222);
        check("err_bpm0",   32'((qb_w.size() > 0) ? qb_w[0] : 12'hFFF), 32'd96);
        check("err_bpm2",   32'((qb_w.size() > 2) ? qb_w[2] : 12'hFFF), 32'h050);
        start_w = 1'b1; step(); start_w = 1'b0;
        check("restart_error",  32'(err_w), 32'd0);
        check("restart_sram_a", 32'(a_w),   32'h3FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
